apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 104 ++++++++++
 tb/tb_apb_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB master FSM (IDLE/SETUP/ACCESS) with async active-high reset.
// Optional ACCESS wait-state timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ASIZE   = 32,
  parameter int DSIZE   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             Pclk,
  input  logic             Presetn,
  input  logic [ASIZE-2:0] addr_temp,
  input  logic [DSIZE-1:0] data_temp,
  input  logic             write_enable,
  input  logic             transfer,
  input  logic             Pready,
  input  logic [DSIZE-1:0] Prdata,
  output logic             Psel,
  output logic             Penable,
  output logic             Pwrite,
  output logic [ASIZE-2:0] Paddr,
  output logic [DSIZE-1:0] Pdata,
  output logic [DSIZE-1:0] rdata_temp,
  output logic             Ptimeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;
  logic   timeout_hit;

  assign Psel    = (state != IDLE);
  assign Penable = (state == ACCESS);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          timeout_q;

  // wait_cnt holds the number of wait cycles already seen in this ACCESS phase
  assign timeout_hit = (state == ACCESS) && !Pready && (wait_cnt == CW'(TIMEOUT - 1));
  assign Ptimeout    = timeout_q;
`else
  // TIMEOUT has no effect in this build; the comparison is constant false
  assign timeout_hit = (TIMEOUT < 0);
  assign Ptimeout    = 1'b0;
`endif

  always_ff @(posedge Pclk or posedge Presetn) begin
    if (Presetn) begin
      state      <= IDLE;
      Pwrite     <= 1'b0;
      Paddr      <= '0;
      Pdata      <= '0;
      rdata_temp <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef APB_MASTER_TIMEOUT_EN
      timeout_q <= timeout_hit;
      if ((state == ACCESS) && !Pready && !timeout_hit)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
`endif
      case (state)
        IDLE: begin
          if (transfer) begin
            state  <= SETUP;
            Paddr  <= addr_temp;
            Pdata  <= data_temp;
            Pwrite <= write_enable;
          end
        end
        SETUP: begin
          state <= ACCESS;
        end
        ACCESS: begin
          if (Pready) begin
            if (!Pwrite)
              rdata_temp <= Prdata;
            if (transfer) begin
              state  <= SETUP;
              Paddr  <= addr_temp;
              Pdata  <= data_temp;
              Pwrite <= write_enable;
            end else begin
              state <= IDLE;
            end
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master: directed vector table,
// reset/timeout sequences and randomized traffic against a transfer-level model.
module tb_apb_master;

  localparam int AW = 31;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          Pclk = 1'b0;
  logic          Presetn = 1'b0;
  logic [AW-1:0] addr_temp = '0;
  logic [DW-1:0] data_temp = '0;
  logic          write_enable = 1'b0;
  logic          transfer = 1'b0;
  logic          Pready = 1'b0;
  logic [DW-1:0] Prdata = '0;
  logic          Psel, Penable, Pwrite, Ptimeout;
  logic [AW-1:0] Paddr;
  logic [DW-1:0] Pdata, rdata_temp;

  apb_master #(.ASIZE(32), .DSIZE(DW), .TIMEOUT(TO)) dut (
    .Pclk(Pclk), .Presetn(Presetn), .addr_temp(addr_temp), .data_temp(data_temp),
    .write_enable(write_enable), .transfer(transfer), .Pready(Pready), .Prdata(Prdata),
    .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pdata(Pdata),
    .rdata_temp(rdata_temp), .Ptimeout(Ptimeout)
  );

  always #5 Pclk = ~Pclk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // bus fields are only meaningful while a transfer is selected
  task automatic check_bus(input string tag, input logic sel, input logic en, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] rd, input logic to);
    check({tag, ".psel"}, 64'(Psel), 64'(sel));
    check({tag, ".penable"}, 64'(Penable), 64'(en));
    check({tag, ".rdata"}, 64'(rdata_temp), 64'(rd));
    check({tag, ".ptimeout"}, 64'(Ptimeout), 64'(to));
    if (sel) begin
      check({tag, ".pwrite"}, 64'(Pwrite), 64'(wr));
      check({tag, ".paddr"}, 64'(Paddr), 64'(a));
      check({tag, ".pdata"}, 64'(Pdata), 64'(d));
    end
  endtask

  task automatic drive(input logic tr, input logic we, input logic rdy,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] prd);
    transfer = tr; write_enable = we; Pready = rdy;
    addr_temp = a; data_temp = d; Prdata = prd;
  endtask

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  typedef struct {
    logic          tr, we, rdy;
    logic [AW-1:0] a;
    logic [DW-1:0] d, prd;
    logic          e_sel, e_en, e_wr;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d, e_rd;
  } vec_t;

  vec_t vec[12];

  // transfer-level reference: age < 0 idle, 0 = setup cycle, n >= 1 = nth access cycle
  int            age;
  logic          m_wr, m_to;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d, m_rd;

  task automatic model_reset();
    age = -1; m_wr = 0; m_a = '0; m_d = '0; m_rd = '0; m_to = 0;
  endtask

  task automatic model_latch();
    age = 0; m_a = addr_temp; m_d = data_temp; m_wr = write_enable;
  endtask

  task automatic model_step();
    m_to = 0;
    if (age < 0) begin
      if (transfer) model_latch();
    end else if (age == 0) begin
      age = 1;
    end else if (Pready) begin
      if (!m_wr) m_rd = Prdata;
      if (transfer) model_latch();
      else age = -1;
    end
`ifdef APB_MASTER_TIMEOUT_EN
    else if (age == TO) begin
      age = -1;
      m_to = 1;
    end
`endif
    else begin
      age++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stall;
    vec[0]  = '{1, 1, 0, 31'h0, 32'hDEADBEEF, 32'h0,        1, 0, 1, 31'h0, 32'hDEADBEEF, 32'h0};
    vec[1]  = '{0, 0, 1, 31'h7F, 32'h1,       32'h0,        1, 1, 1, 31'h0, 32'hDEADBEEF, 32'h0};
    vec[2]  = '{0, 0, 1, 31'h0, 32'h0,        32'h0,        0, 0, 0, 31'h0, 32'h0,        32'h0};
    vec[3]  = '{1, 0, 0, 31'h4, 32'h55,       32'h0,        1, 0, 0, 31'h4, 32'h55,       32'h0};
    vec[4]  = '{1, 0, 0, 31'h4, 32'h55,       32'h0,        1, 1, 0, 31'h4, 32'h55,       32'h0};
    vec[5]  = '{1, 0, 0, 31'h4, 32'h55,       32'hAAAAAAAA, 1, 1, 0, 31'h4, 32'h55,       32'h0};
    vec[6]  = '{1, 0, 0, 31'h4, 32'h55,       32'hAAAAAAAA, 1, 1, 0, 31'h4, 32'h55,       32'h0};
    vec[7]  = '{1, 0, 0, 31'h4, 32'h55,       32'hAAAAAAAA, 1, 1, 0, 31'h4, 32'h55,       32'h0};
    vec[8]  = '{1, 1, 1, 31'h8, 32'hCAFEF00D, 32'h12345678, 1, 0, 1, 31'h8, 32'hCAFEF00D, 32'h12345678};
    vec[9]  = '{0, 0, 0, 31'h0, 32'h0,        32'h0,        1, 1, 1, 31'h8, 32'hCAFEF00D, 32'h12345678};
    vec[10] = '{0, 0, 1, 31'h0, 32'h0,        32'hFFFF0000, 0, 0, 0, 31'h0, 32'h0,        32'h12345678};
    vec[11] = '{0, 0, 1, 31'h0, 32'h0,        32'h00009999, 0, 0, 0, 31'h0, 32'h0,        32'h12345678};

    // asynchronous reset before any clock edge
    #2 Presetn = 1'b1;
    #1;
    check("rst.psel", 64'(Psel), 64'd0);
    check("rst.penable", 64'(Penable), 64'd0);
    check("rst.pwrite", 64'(Pwrite), 64'd0);
    check("rst.paddr", 64'(Paddr), 64'd0);
    check("rst.pdata", 64'(Pdata), 64'd0);
    check("rst.rdata", 64'(rdata_temp), 64'd0);
    check("rst.ptimeout", 64'(Ptimeout), 64'd0);
    tick();
    Presetn = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vec[i].tr, vec[i].we, vec[i].rdy, vec[i].a, vec[i].d, vec[i].prd);
      tick();
      check_bus($sformatf("vec%0d", i), vec[i].e_sel, vec[i].e_en, vec[i].e_wr,
                vec[i].e_a, vec[i].e_d, vec[i].e_rd, 1'b0);
    end

    // reset asserted between edges while in ACCESS
    drive(1, 0, 0, 31'h10, 32'h77, 32'h0);
    tick();
    drive(0, 0, 0, 31'h0, 32'h0, 32'h0);
    tick();
    check("midrst.pre_penable", 64'(Penable), 64'd1);
    #3 Presetn = 1'b1;
    #1;
    check("midrst.psel", 64'(Psel), 64'd0);
    check("midrst.penable", 64'(Penable), 64'd0);
    check("midrst.paddr", 64'(Paddr), 64'd0);
    check("midrst.pdata", 64'(Pdata), 64'd0);
    check("midrst.rdata", 64'(rdata_temp), 64'd0);
    drive(1, 0, 1, 31'h10, 32'h77, 32'h5A5A5A5A);
    tick();
    check("midrst.held_psel", 64'(Psel), 64'd0);
    drive(0, 0, 1, 31'h10, 32'h77, 32'h5A5A5A5A);
    Presetn = 1'b0;
    tick();
    check_bus("postrst.idle", 0, 0, 0, 31'h0, 32'h0, 32'h0, 1'b0);
    drive(1, 1, 1, 31'h20, 32'h3C3C3C3C, 32'h5A5A5A5A);
    tick();
    check_bus("postrst.setup", 1, 0, 1, 31'h20, 32'h3C3C3C3C, 32'h0, 1'b0);
    drive(0, 0, 1, 31'h0, 32'h0, 32'h5A5A5A5A);
    tick();
    check_bus("postrst.access", 1, 1, 1, 31'h20, 32'h3C3C3C3C, 32'h0, 1'b0);
    tick();
    check_bus("postrst.done", 0, 0, 0, 31'h0, 32'h0, 32'h0, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
    drive(1, 0, 0, 31'h40, 32'h0, 32'hBADBAD00);
    tick();
    drive(0, 0, 0, 31'h0, 32'h0, 32'hBADBAD00);
    tick();
    for (int k = 1; k < TO; k++) begin
      tick();
      check_bus($sformatf("tmo.wait%0d", k), 1, 1, 0, 31'h40, 32'h0, 32'h0, 1'b0);
    end
    tick();
    check_bus("tmo.fire", 0, 0, 0, 31'h0, 32'h0, 32'h0, 1'b1);
    tick();
    check_bus("tmo.after", 0, 0, 0, 31'h0, 32'h0, 32'h0, 1'b0);
`endif

    // randomized traffic against the reference model
    Presetn = 1'b1;
    drive(0, 0, 0, 31'h0, 32'h0, 32'h0);
    tick();
    Presetn = 1'b0;
    model_reset();
    stall = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) stall = 20;
      drive($urandom_range(0, 3) != 0, 1'($urandom), 1'b0,
            AW'($urandom), $urandom, $urandom);
      if (stall > 0) stall--;
      else Pready = ($urandom_range(0, 2) != 0);
      model_step();
      tick();
      check_bus($sformatf("rnd%0d", c), age >= 0, age >= 1, m_wr, m_a, m_d, m_rd, m_to);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
